// File: rtl/mod_m_burst_ctrl_pkg.sv
// Shared definitions for the mod-M burst controller: FSM state encodings and minimum modulus.
package mod_m_burst_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int MOD_M_MIN = 2;

endpackage

// File: rtl/mod_m_burst_ctrl_prescaler.sv
// Modulo-M counter datapath: counts 0..m-1 while enabled, clr forces 0.
// wrap flags the terminal count q == m-1; the caller qualifies it with en.
module mod_m_burst_ctrl_prescaler #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [N-1:0] m,
   output logic [N-1:0] q,
   output logic         wrap
);

   logic [N-1:0] q_q, q_d;

   assign wrap = (q_q == m - N'(1));
   assign q    = q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = wrap ? '0 : q_q + N'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/mod_m_burst_ctrl.sv
// Burst sequencer around a modulo-M prescaler: runs a latched number of full periods per start.
// Define MOD_M_BURST_AUTORELOAD_EN to restart each burst automatically until abort or reset.
//
// state   | meaning
// IDLE    | waiting for start, counter held at 0
// LOAD    | config latched, one cycle before counting
// RUN     | counter running, periods_left decrements on each wrap
// DONE    | one-cycle done pulse
module mod_m_burst_ctrl
   import mod_m_burst_ctrl_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [N-1:0]     cfg_m,
   input  logic [CNT_W-1:0] cfg_bursts,
   output logic             busy,
   output logic             done,
   output logic             tick,
   output logic [N-1:0]     q,
   output logic [CNT_W-1:0] periods_left
);

   state_e           state_q, state_d;
   logic [N-1:0]     m_lat_q, m_lat_d;
   logic [CNT_W-1:0] periods_left_q, periods_left_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             run, wrap, cnt_clr;
`ifdef MOD_M_BURST_AUTORELOAD_EN
   logic [CNT_W-1:0] bursts_lat_q, bursts_lat_d;
`endif

   assign run     = (state_q == ST_RUN);
   assign tick    = run & wrap;
   assign cnt_clr = run & abort;

   mod_m_burst_ctrl_prescaler #(.N(N)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .clr   (cnt_clr),
      .m     (m_lat_q),
      .q     (q),
      .wrap  (wrap)
   );

   always_comb begin
      state_d        = state_q;
      m_lat_d        = m_lat_q;
      periods_left_d = periods_left_q;
`ifdef MOD_M_BURST_AUTORELOAD_EN
      bursts_lat_d   = bursts_lat_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d        = ST_LOAD;
               m_lat_d        = (cfg_m < N'(MOD_M_MIN)) ? N'(MOD_M_MIN) : cfg_m;
               periods_left_d = cfg_bursts;
`ifdef MOD_M_BURST_AUTORELOAD_EN
               bursts_lat_d   = cfg_bursts;
`endif
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d        = ST_IDLE;
               periods_left_d = '0;
            end else if (periods_left_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // abort wins over a coincident final wrap, so no done pulse follows
            if (abort) begin
               state_d        = ST_IDLE;
               periods_left_d = '0;
            end else if (tick && periods_left_q != '0) begin
               periods_left_d = periods_left_q - CNT_W'(1);
               if (periods_left_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
`ifdef MOD_M_BURST_AUTORELOAD_EN
            state_d        = ST_LOAD;
            periods_left_d = bursts_lat_q;
`else
            state_d        = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         m_lat_q        <= N'(MOD_M_MIN);
         periods_left_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
`ifdef MOD_M_BURST_AUTORELOAD_EN
         bursts_lat_q   <= '0;
`endif
      end else begin
         state_q        <= state_d;
         m_lat_q        <= m_lat_d;
         periods_left_q <= periods_left_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
`ifdef MOD_M_BURST_AUTORELOAD_EN
         bursts_lat_q   <= bursts_lat_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign periods_left = periods_left_q;

endmodule

// File: tb/tb_mod_m_burst_ctrl.sv
// Self-checking bench for mod_m_burst_ctrl (single-burst build): scoreboard of expected
// tick/done events plus a per-cycle arithmetic model of busy, q and periods_left.
module tb_mod_m_burst_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [3:0] cfg_m;
   logic [7:0] cfg_bursts;
   logic       busy, done, tick;
   logic [3:0] q;
   logic [7:0] periods_left;

   mod_m_burst_ctrl #(.N(4), .CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .cfg_m        (cfg_m),
      .cfg_bursts   (cfg_bursts),
      .busy         (busy),
      .done         (done),
      .tick         (tick),
      .q            (q),
      .periods_left (periods_left)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  ecount = 0;
   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 0;

   // model of the current burst: LOAD in interval k, last busy interval end_busy
   int  mdl_k = -1000;
   int  mdl_m = 2;
   int  mdl_end = -1001;

   always @(posedge clk) ecount <= ecount + 1;

   function automatic int exp_q_val(int t);
      if (t >= mdl_k + 1 && t <= mdl_end) return (t - mdl_k - 1) % mdl_m;
      return 0;
   endfunction

   function automatic int exp_pl_val(int t, int b);
      if (t < mdl_k || t > mdl_end) return -1;
      if (t == mdl_k) return b;
      return b - ((t - mdl_k - 1) / mdl_m);
   endfunction

   int mdl_b = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < ecount) begin
            checks++;
            errors++;
            $display("FAIL missed_event done=%0d: expected at cycle %0d, not seen by %0d",
                     exp_q[0].is_done, exp_q[0].cyc, ecount);
            void'(exp_q.pop_front());
         end
         checks++;
         if (busy !== (ecount >= mdl_k && ecount <= mdl_end)) begin
            errors++;
            $display("FAIL busy cyc=%0d: got %b want %b", ecount, busy,
                     (ecount >= mdl_k && ecount <= mdl_end));
         end
         checks++;
         if (q !== 4'(exp_q_val(ecount))) begin
            errors++;
            $display("FAIL q cyc=%0d: got %0d want %0d", ecount, q, exp_q_val(ecount));
         end
         if (exp_pl_val(ecount, mdl_b) >= 0) begin
            checks++;
            if (periods_left !== 8'(exp_pl_val(ecount, mdl_b))) begin
               errors++;
               $display("FAIL periods_left cyc=%0d: got %0d want %0d", ecount, periods_left,
                        exp_pl_val(ecount, mdl_b));
            end
         end
         if (tick === 1'b1 || done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event cyc=%0d: tick=%b done=%b, none expected",
                        ecount, tick, done);
            end else begin
               if (exp_q[0].cyc != ecount || exp_q[0].is_done != done || tick === done) begin
                  errors++;
                  $display("FAIL event cyc=%0d: got tick=%b done=%b want done=%0d at cyc %0d",
                           ecount, tick, done, exp_q[0].is_done, exp_q[0].cyc);
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic truncate_at(int a);
      mdl_end = a;
      while (exp_q.size() > 0 && exp_q[$].cyc > a) void'(exp_q.pop_back());
   endtask

   // Issue one burst from IDLE and drive it to completion; abort_off < 0 means no abort.
   task automatic run_burst(int m_in, int b_in, int abort_off, bit use_reset, bit noise);
      int mk, idle_from;
      mk = (m_in < 2) ? 2 : m_in;
      cfg_m      = 4'(m_in);
      cfg_bursts = 8'(b_in);
      start      = 1'b1;
      abort      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mdl_k   = ecount + 1;
      mdl_m   = mk;
      mdl_b   = b_in;
      mdl_end = mdl_k + mk * b_in;
      for (int j = 1; j <= b_in; j++) exp_q.push_back('{is_done: 1'b0, cyc: mdl_k + mk * j});
      exp_q.push_back('{is_done: 1'b1, cyc: mdl_end + 1});
      idle_from = mdl_end + 2;
      step();
      start = 1'b0;
      abort = 1'b0;
      while (ecount < idle_from) begin
         if (abort_off >= 0 && ecount == mdl_k + abort_off) begin
            if (use_reset) reset = 1'b0;
            else abort = 1'b1;
            truncate_at(ecount);
            idle_from = ecount + 1;
         end
         if (noise) begin
            start      = 1'($urandom_range(0, 1));
            cfg_m      = 4'($urandom);
            cfg_bursts = 8'($urandom);
         end
         step();
         reset = 1'b1;
         abort = 1'b0;
         start = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b1;
      abort = 1'b0;
      cfg_m = 4'd5;
      cfg_bursts = 8'd3;
      step();
      mon_en = 1;
      step();
      reset = 1'b1;
      start = 1'b0;
      step();

      run_burst(5, 3, -1, 0, 0);
      step();
      run_burst(1, 2, -1, 0, 0);
      run_burst(0, 2, -1, 0, 0);
      run_burst(7, 0, -1, 0, 0);
      run_burst(4, 2, 8, 0, 0);
      run_burst(4, 2, 0, 0, 0);
      run_burst(6, 3, 9, 1, 0);
      run_burst(5, 3, -1, 0, 1);
      run_burst(15, 2, -1, 0, 1);

      for (int i = 0; i < 40; i++) begin
         int m_r, b_r, mk, ab;
         m_r = $urandom_range(0, 15);
         b_r = $urandom_range(0, 4);
         mk  = (m_r < 2) ? 2 : m_r;
         ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, mk * b_r) : -1;
         run_burst(m_r, b_r, ab, (ab >= 0) && ($urandom_range(0, 3) == 0), 1);
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            abort = 1'($urandom_range(0, 1));
            step();
         end
         abort = 1'b0;
      end

      step();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d events left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, want finish");
      $fatal(1, "timeout");
   end

endmodule
